// File: rtl/tft_pkg.sv
// Shared timing constants, RGB565 colours and FSM encoding for the
// 480x272 TFT timing controller.
package tft_pkg;

   localparam int H_SYNC  = 41;
   localparam int H_BACK  = 2;
   localparam int H_VALID = 480;
   localparam int H_FRONT = 2;
   localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;

   localparam int V_SYNC  = 10;
   localparam int V_BACK  = 2;
   localparam int V_VALID = 272;
   localparam int V_FRONT = 2;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

   localparam logic [15:0] BLACK  = 16'h0000;
   localparam logic [15:0] WHITE  = 16'hFFFF;
   localparam logic [15:0] RED    = 16'hF800;
   localparam logic [15:0] GREEN  = 16'h07E0;
   localparam logic [15:0] BLUE   = 16'h001F;
   localparam logic [15:0] GOLDEN = 16'hFEC0;

   // Coordinate value reported outside the pixel-request window.
   localparam logic [9:0] COORD_NONE = 10'h3FF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/tft_ctrl.sv
// Sync/DE/backlight generator with a one-clock-early pixel request and a
// display-enable FSM that only starts/stops scanning on frame boundaries.
module tft_ctrl
   import tft_pkg::*;
#(
   parameter int P_H_SYNC  = H_SYNC,
   parameter int P_H_BACK  = H_BACK,
   parameter int P_H_VALID = H_VALID,
   parameter int P_H_FRONT = H_FRONT,
   parameter int P_V_SYNC  = V_SYNC,
   parameter int P_V_BACK  = V_BACK,
   parameter int P_V_VALID = V_VALID,
   parameter int P_V_FRONT = V_FRONT
) (
   input  logic        tft_clk,
   input  logic        sys_rst,
   input  logic        disp_en,
   input  logic [15:0] pix_data,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [15:0] rgb_tft,
   output logic        hsync,
   output logic        vsync,
   output logic        tft_de,
   output logic        tft_bl,
   output logic        tft_clk_o,
   output logic        frame_start,
   output logic [1:0]  dbg_state
);

   localparam logic [9:0] L_H_SYNC_END = 10'(P_H_SYNC);
   localparam logic [9:0] L_H_DE_BEG   = 10'(P_H_SYNC + P_H_BACK);
   localparam logic [9:0] L_H_DE_END   = 10'(P_H_SYNC + P_H_BACK + P_H_VALID);
   localparam logic [9:0] L_H_REQ_BEG  = L_H_DE_BEG - 10'd1;
   localparam logic [9:0] L_H_REQ_END  = L_H_DE_END - 10'd1;
   localparam logic [9:0] L_H_LAST     = 10'(P_H_SYNC + P_H_BACK + P_H_VALID + P_H_FRONT - 1);
   localparam logic [9:0] L_V_SYNC_END = 10'(P_V_SYNC);
   localparam logic [9:0] L_V_DE_BEG   = 10'(P_V_SYNC + P_V_BACK);
   localparam logic [9:0] L_V_DE_END   = 10'(P_V_SYNC + P_V_BACK + P_V_VALID);
   localparam logic [9:0] L_V_LAST     = 10'(P_V_SYNC + P_V_BACK + P_V_VALID + P_V_FRONT - 1);

   state_t     r_state;
   state_t     w_next_state;
   logic [9:0] r_cnt_h;
   logic [9:0] r_cnt_v;
   logic       w_scan;
   logic       w_eol;
   logic       w_eof;
   logic       w_h_de;
   logic       w_h_req;
   logic       w_v_act;
   logic       w_rgb_valid;
   logic       w_pix_req;

   assign w_scan = (r_state != ST_IDLE);
   assign w_eol  = (r_cnt_h == L_H_LAST);
   assign w_eof  = w_eol && (r_cnt_v == L_V_LAST);

   always_ff @(posedge tft_clk or posedge sys_rst) begin
      if (sys_rst) r_state <= ST_IDLE;
      else         r_state <= w_next_state;
   end

   // DRAIN keeps the scan alive so a dropped request never truncates a frame.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (disp_en) w_next_state = ST_RUN;
         ST_RUN:   if (!disp_en) w_next_state = w_eof ? ST_IDLE : ST_DRAIN;
         ST_DRAIN: begin
            if (disp_en)    w_next_state = ST_RUN;
            else if (w_eof) w_next_state = ST_IDLE;
         end
         default:  w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge tft_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_cnt_h <= '0;
         r_cnt_v <= '0;
      end else if (r_state == ST_IDLE) begin
         r_cnt_h <= '0;
         r_cnt_v <= '0;
      end else begin
         r_cnt_h <= w_eol ? 10'd0 : r_cnt_h + 10'd1;
         if (w_eol) r_cnt_v <= (r_cnt_v == L_V_LAST) ? 10'd0 : r_cnt_v + 10'd1;
      end
   end

   assign w_h_de      = (r_cnt_h >= L_H_DE_BEG)  && (r_cnt_h < L_H_DE_END);
   assign w_h_req     = (r_cnt_h >= L_H_REQ_BEG) && (r_cnt_h < L_H_REQ_END);
   assign w_v_act     = (r_cnt_v >= L_V_DE_BEG)  && (r_cnt_v < L_V_DE_END);
   assign w_rgb_valid = w_scan && w_h_de  && w_v_act;
   assign w_pix_req   = w_scan && w_h_req && w_v_act;

   always_comb begin
      hsync       = 1'b0;
      vsync       = 1'b0;
      tft_bl      = 1'b0;
      frame_start = 1'b0;
      if (w_scan) begin
         hsync       = (r_cnt_h < L_H_SYNC_END);
         vsync       = (r_cnt_v < L_V_SYNC_END);
         tft_bl      = 1'b1;
         frame_start = (r_cnt_h == 10'd0) && (r_cnt_v == 10'd0);
      end
      pix_x   = w_pix_req ? (r_cnt_h - L_H_REQ_BEG) : COORD_NONE;
      pix_y   = w_pix_req ? (r_cnt_v - L_V_DE_BEG) : COORD_NONE;
      rgb_tft = w_rgb_valid ? pix_data : BLACK;
      tft_de  = w_rgb_valid;
   end

   assign tft_clk_o = tft_clk;
   assign dbg_state = r_state;

endmodule
